// File: rtl/ras_ctrl.sv
// Return address stack with checkpoint/rollback for speculative fetch.
// A FIFO of {tos, cnt} snapshots allows rollback to the oldest unresolved prediction.
module ras_ctrl #(
    parameter int SIZE = 4,
    parameter int CKPT = 4
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_enable_i,
    input  logic        s_push_i,
    input  logic [30:0] s_push_addr_i,
    input  logic        s_pop_i,
    input  logic        s_ckpt_i,
    input  logic        s_resolve_i,
    input  logic        s_restore_i,
    input  logic        s_invalidate_i,
    output logic [30:0] s_top_addr_o,
    output logic        s_top_valid_o,
    output logic        s_ckpt_full_o,
    output logic        s_busy_o
);
    localparam int TW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW = $clog2(SIZE + 1);
    localparam int PW = (CKPT > 1) ? $clog2(CKPT) : 1;
    localparam int OW = $clog2(CKPT + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(SIZE);
    localparam logic [OW-1:0] OCC_MAX  = OW'(CKPT);
    localparam logic [TW-1:0] LAST_IDX = TW'(SIZE - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(CKPT - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    typedef struct packed {
        logic [TW-1:0] tos;
        logic [CW-1:0] cnt;
    } ckpt_t;

    state_e        state_q, state_d;
    logic [TW-1:0] tos_q, tos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] clr_idx_q, clr_idx_d;
    logic [SIZE-1:0] valid_q;
    logic [30:0]   addr_q [SIZE];

    ckpt_t         fifo_q [CKPT];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [OW-1:0] occ_q;

    logic          wr_en;
    logic [TW-1:0] wr_idx;
    logic          valid_clr;
    logic          fifo_clear;
    logic          enq;
    logic          deq;
    ckpt_t         head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head = fifo_q[rd_ptr_q];

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        tos_d      = tos_q;
        cnt_d      = cnt_q;
        clr_idx_d  = clr_idx_q;
        wr_en      = 1'b0;
        wr_idx     = tos_q;
        valid_clr  = 1'b0;
        fifo_clear = 1'b0;
        enq        = 1'b0;
        deq        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_invalidate_i) begin
                    state_d    = CLEAR;
                    tos_d      = '0;
                    cnt_d      = '0;
                    clr_idx_d  = '0;
                    fifo_clear = 1'b1;
                end else if (s_restore_i && occ_q != '0) begin
                    tos_d      = head.tos;
                    cnt_d      = head.cnt;
                    fifo_clear = 1'b1;
                end else begin
                    if (s_push_i && s_pop_i && cnt_q != '0) begin
                        // Call replacing a return: overwrite the top in place.
                        wr_en  = 1'b1;
                        wr_idx = tos_q;
                    end else if (s_push_i) begin
                        tos_d  = tos_q + 1'b1;
                        wr_en  = 1'b1;
                        wr_idx = tos_q + 1'b1;
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    end else if (s_pop_i && cnt_q != '0) begin
                        tos_d = tos_q - 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end
                    deq = s_resolve_i && occ_q != '0;
                    // A same-cycle release frees the slot the new snapshot needs.
                    enq = s_ckpt_i && (occ_q != OCC_MAX || deq);
                end
            end
            CLEAR: begin
                valid_clr = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q   <= IDLE;
            tos_q     <= '0;
            cnt_q     <= '0;
            clr_idx_q <= '0;
            valid_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            tos_q     <= tos_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;

            if (valid_clr)  valid_q[clr_idx_q] <= 1'b0;
            else if (wr_en) valid_q[wr_idx]    <= 1'b1;

            if (fifo_clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
                unique case ({enq, deq})
                    2'b10:   occ_q <= occ_q + 1'b1;
                    2'b01:   occ_q <= occ_q - 1'b1;
                    default: occ_q <= occ_q;
                endcase
            end
        end
    end

    // NOTE: payload storage is left unreset; the valid bits and occupancy
    // counters already guard every read, so resetting data only costs area.
    always_ff @(posedge s_clk_i) begin
        if (wr_en) addr_q[wr_idx]   <= s_push_addr_i;
        if (enq)   fifo_q[wr_ptr_q] <= '{tos: tos_d, cnt: cnt_d};
    end

    assign s_top_addr_o  = addr_q[tos_q];
    assign s_top_valid_o = (cnt_q != '0) && valid_q[tos_q] && s_enable_i && (state_q == IDLE);
    assign s_ckpt_full_o = (occ_q == OCC_MAX);
    assign s_busy_o      = (state_q == CLEAR);

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_ras_ctrl;
    localparam logic [7:0] PUSH = 8'h01;
    localparam logic [7:0] POP  = 8'h02;
    localparam logic [7:0] CKP  = 8'h04;
    localparam logic [7:0] RES  = 8'h08;
    localparam logic [7:0] RSTO = 8'h10;
    localparam logic [7:0] INV  = 8'h20;
    localparam logic [7:0] RST  = 8'h40;
    localparam logic [7:0] NOEN = 8'h80;

    typedef struct packed {
        logic        busy;
        logic        full;
        logic        valid;
        logic [30:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        push = 1'b0;
    logic [30:0] push_addr = '0;
    logic        pop = 1'b0;
    logic        ckpt = 1'b0;
    logic        resolve = 1'b0;
    logic        restore = 1'b0;
    logic        invalidate = 1'b0;
    logic [30:0] top_addr;
    logic        top_valid;
    logic        ckpt_full;
    logic        busy;

    logic        strobe = 1'b0;
    exp_t        exp_q[$];
    string       name_q[$];
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    ras_ctrl #(.SIZE(4), .CKPT(4)) dut (
        .s_clk_i        (clk),
        .s_reset_i      (reset),
        .s_enable_i     (enable),
        .s_push_i       (push),
        .s_push_addr_i  (push_addr),
        .s_pop_i        (pop),
        .s_ckpt_i       (ckpt),
        .s_resolve_i    (resolve),
        .s_restore_i    (restore),
        .s_invalidate_i (invalidate),
        .s_top_addr_o   (top_addr),
        .s_top_valid_o  (top_valid),
        .s_ckpt_full_o  (ckpt_full),
        .s_busy_o       (busy)
    );

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got {busy,full,valid,addr}=%h required %h", name, act, req);
    endtask

    // Applies one cycle of inputs; its effect is visible from the next tick.
    task automatic tick(input logic [7:0] ops, input logic [30:0] addr);
        @(posedge clk);
        #1;
        strobe     = 1'b0;
        push       = ops[0];
        pop        = ops[1];
        ckpt       = ops[2];
        resolve    = ops[3];
        restore    = ops[4];
        invalidate = ops[5];
        reset      = ops[6];
        enable     = ~ops[7];
        push_addr  = addr;
    endtask

    // Expectation for the state produced by all earlier ticks.
    task automatic expect_now(input string name, input logic valid, input logic [30:0] addr,
                              input logic full, input logic bsy);
        exp_t e;
        e.busy  = bsy;
        e.full  = full;
        e.valid = valid;
        e.addr  = valid ? addr : 31'h0;
        exp_q.push_back(e);
        name_q.push_back(name);
        strobe = 1'b1;
    endtask

    always @(negedge clk) begin
        if (strobe) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 34'h1, 34'h0);
            end else begin
                exp_t  e;
                exp_t  a;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a.busy  = busy;
                a.full  = ckpt_full;
                a.valid = top_valid;
                a.addr  = e.valid ? top_addr : 31'h0;
                check(n, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tick(RST, '0);
        tick(RST, '0);
        tick(8'h00, '0);      expect_now("reset", 0, '0, 0, 0);

        // Basic LIFO and underflow
        tick(PUSH, 31'h100);
        tick(PUSH, 31'h200);
        tick(PUSH, 31'h300);
        tick(POP, '0);        expect_now("r32_top300", 1, 31'h300, 0, 0);
        tick(POP, '0);        expect_now("r32_pop200", 1, 31'h200, 0, 0);
        tick(POP, '0);        expect_now("r32_pop100", 1, 31'h100, 0, 0);
        tick(POP, '0);        expect_now("r32_empty", 0, '0, 0, 0);
        tick(8'h00, '0);      expect_now("r32_underflow", 0, '0, 0, 0);

        // Overflow wraps and overwrites the oldest entry
        tick(PUSH, 31'h10);
        tick(PUSH, 31'h20);
        tick(PUSH, 31'h30);
        tick(PUSH, 31'h40);
        tick(PUSH, 31'h50);
        tick(POP, '0);        expect_now("r33_top50", 1, 31'h50, 0, 0);
        tick(POP, '0);        expect_now("r33_pop40", 1, 31'h40, 0, 0);
        tick(POP, '0);        expect_now("r33_pop30", 1, 31'h30, 0, 0);
        tick(POP, '0);        expect_now("r33_pop20", 1, 31'h20, 0, 0);
        tick(8'h00, '0);      expect_now("r33_empty", 0, '0, 0, 0);

        // Push+pop in one cycle, with and without entries
        tick(PUSH, 31'hA0);
        tick(PUSH | POP, 31'hB0);
        tick(POP, '0);        expect_now("r34_replace", 1, 31'hB0, 0, 0);
        tick(PUSH | POP, 31'hC0); expect_now("r34_empty", 0, '0, 0, 0);
        tick(POP, '0);        expect_now("r34_pushpop_empty", 1, 31'hC0, 0, 0);
        tick(8'h00, '0);      expect_now("r34_popped", 0, '0, 0, 0);

        // Checkpoint and restore; same-cycle push must be ignored
        tick(PUSH, 31'h100);
        tick(CKP, '0);
        tick(PUSH, 31'h200);
        tick(POP, '0);
        tick(POP, '0);
        tick(RSTO | PUSH, 31'h3FF);
        tick(POP, '0);        expect_now("r35_restore", 1, 31'h100, 0, 0);
        tick(RSTO, '0);       expect_now("r35_popped", 0, '0, 0, 0);
        tick(8'h00, '0);      expect_now("r35_fifo_empty", 0, '0, 0, 0);

        // Checkpoint FIFO full, drop, release
        tick(CKP, '0);
        tick(CKP, '0);
        tick(CKP, '0);
        tick(CKP, '0);        expect_now("r36_three", 0, '0, 0, 0);
        tick(CKP, '0);        expect_now("r36_full", 0, '0, 1, 0);
        tick(RES, '0);        expect_now("r36_drop", 0, '0, 1, 0);
        tick(CKP, '0);        expect_now("r36_release", 0, '0, 0, 0);
        tick(RES | CKP, '0);  expect_now("r36_refill", 0, '0, 1, 0);
        tick(8'h00, '0);      expect_now("r36_res_ckpt", 0, '0, 1, 0);

        // Invalidate sequence lasts SIZE cycles and blocks all operations
        tick(PUSH, 31'h11);
        tick(PUSH, 31'h22);
        tick(PUSH, 31'h33);
        tick(INV, '0);        expect_now("r37_before", 1, 31'h33, 1, 0);
        tick(PUSH, 31'h44);   expect_now("r37_busy0", 0, '0, 0, 1);
        tick(PUSH, 31'h55);   expect_now("r37_busy1", 0, '0, 0, 1);
        tick(INV, '0);        expect_now("r37_busy2", 0, '0, 0, 1);
        tick(POP, '0);        expect_now("r37_busy3", 0, '0, 0, 1);
        tick(PUSH, 31'h66);   expect_now("r37_done", 0, '0, 0, 0);
        tick(NOEN, '0);       expect_now("r37_disabled", 0, '0, 0, 0);
        tick(POP, '0);        expect_now("r37_push_after", 1, 31'h66, 0, 0);
        tick(8'h00, '0);      expect_now("r37_empty", 0, '0, 0, 0);

        // Restore goes to the oldest unresolved checkpoint, captured post-push
        tick(PUSH, 31'h700);
        tick(CKP, '0);
        tick(PUSH | CKP, 31'h710);
        tick(RES, '0);
        tick(POP, '0);
        tick(POP, '0);
        tick(RSTO, '0);       expect_now("oldest_pre", 0, '0, 0, 0);
        tick(8'h00, '0);      expect_now("oldest_restore", 1, 31'h710, 0, 0);

        // Reset aborts an invalidate sequence
        tick(INV, '0);
        tick(8'h00, '0);      expect_now("abort_busy", 0, '0, 0, 1);
        tick(RST, '0);        expect_now("abort_busy2", 0, '0, 0, 1);
        tick(PUSH, 31'h5A);   expect_now("abort_reset", 0, '0, 0, 0);
        tick(8'h00, '0);      expect_now("abort_push", 1, 31'h5A, 0, 0);

        tick(8'h00, '0);
        tick(8'h00, '0);
        check("scoreboard_drain", 34'(exp_q.size()), 34'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
